serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor: sequences a single full-subtractor cell (x, y, borrow-in → diff, borrow) over a WIDTH-bit operand pair, one bit per clock, LSB first. Computes diff = a − b − borrow_in with start/busy/done handshake. Sits beside the combinational subtractor datapath in the lab design as the area-minimal alternative to a ripple chain. Results are registered and held stable between operations.

---
 rtl/serial_subtractor_ctrl.sv | 107 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - borrow_in, LSB first, one full-subtractor step per clock; ovf port with SERIAL_SUB_OVF_EN.
// Latency: WIDTH cycles from accepted start to done; one further DONE cycle before IDLE.
// No backpressure: start is only sampled in IDLE, ignored (not queued) while busy or done.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             x, y, sbit, bout, last;

  // Single full-subtractor cell shared by every bit position
  assign x    = a_sh[0];
  assign y    = b_sh[0];
  assign sbit = x ^ y ^ brw;
  assign bout = (~x & (y ^ brw)) | (y & brw);
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= borrow_in;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= {sbit, r_sh[WIDTH-1:1]};
          brw  <= bout;
          if (last) begin
            // Result is published on the same edge the MSB is computed
            cnt        <= '0;
            diff       <= {sbit, r_sh[WIDTH-1:1]};
            borrow_out <= bout;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= brw ^ bout;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random operations on serial_subtractor_ctrl, checked against an arithmetic model.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         borrow_in;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
  logic         exp_ovf;
`endif

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_diff;
  logic         exp_bo;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned difference and its sign give diff/borrow
  task automatic ref_sub(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                         output logic [W-1:0] d, output logic bo);
    longint r;
    r  = longint'(ta) - longint'(tb_) - longint'(tbin);
    bo = (r < 0);
    d  = r[W-1:0];
  endtask

`ifdef SERIAL_SUB_OVF_EN
  function automatic logic ref_ovf(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    longint r, lim;
    lim = longint'(1) <<< (W - 1);
    r   = longint'($signed(ta)) - longint'($signed(tb_)) - longint'(tbin);
    return (r >= lim) || (r < -lim);
  endfunction
`endif

  // One full operation: accept edge k, WIDTH busy cycles, done at k+W, idle at k+W+1
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                       input bit inject);
    logic [W-1:0] nd;
    logic         nb;
    ref_sub(ta, tb_, tbin, nd, nb);
    @(negedge clk);
    a = ta; b = tb_; borrow_in = tbin; start = 1'b1;
    @(posedge clk); #1;
    check("busy_at_accept", busy, 1'b1);
    check("done_at_accept", done, 1'b0);
    for (int cyc = 1; cyc < W; cyc++) begin
      start     = inject && (cyc == 3);
      a         = W'($urandom);
      b         = W'($urandom);
      borrow_in = 1'($urandom);
      @(posedge clk); #1;
      check("busy_shift", busy, 1'b1);
      check("done_shift", done, 1'b0);
      check("diff_held", diff, exp_diff);
      check("borrow_held", borrow_out, exp_bo);
    end
    start = inject;
    @(posedge clk); #1;
    start = 1'b0;
    exp_diff = nd;
    exp_bo   = nb;
`ifdef SERIAL_SUB_OVF_EN
    exp_ovf = ref_ovf(ta, tb_, tbin);
    check("ovf_result", ovf, exp_ovf);
`endif
    check("done_pulse", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("diff_result", diff, exp_diff);
    check("borrow_result", borrow_out, exp_bo);
    @(posedge clk); #1;
    check("done_falls", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("diff_after_done", diff, exp_diff);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    exp_diff = '0; exp_bo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, '0);
    check("rst_borrow", borrow_out, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", busy, 1'b0);

    do_op(8'h35, 8'h12, 1'b0, 1'b0);
    check("dir_35_12", diff, 8'h23);
    do_op(8'h12, 8'h35, 1'b0, 1'b0);
    check("dir_12_35", {borrow_out, diff}, 9'h1DD);
    do_op(8'h00, 8'h00, 1'b1, 1'b0);
    check("dir_00_00_b1", {borrow_out, diff}, 9'h1FF);
    do_op(8'h5A, 8'h3C, 1'b0, 1'b1);
    check("ignored_start", diff, 8'h1E);
    do_op(8'hC3, 8'h44, 1'b1, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    do_op(8'h80, 8'h01, 1'b0, 1'b0);
    check("ovf_80_01", {ovf, borrow_out, diff}, 10'h07F | 10'h200);
    do_op(8'h05, 8'h03, 1'b0, 1'b0);
    check("ovf_05_03", {ovf, borrow_out, diff}, 10'h002);
`endif

    // Reset aborts an operation in flight
    @(negedge clk);
    a = 8'h99; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_diff = '0;
    exp_bo   = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, exp_diff);
    check("abort_borrow", borrow_out, exp_bo);
`ifdef SERIAL_SUB_OVF_EN
    exp_ovf = 1'b0;
    check("abort_ovf", ovf, exp_ovf);
`endif
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    do_op(8'h7E, 8'h7F, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
